// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS core.
// Optional MDU_EARLY_OUT_EN: short multipliers finish after WIDTH/2 steps.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div_q, div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 bz_q, bz_d;
    logic                 early_q, early_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic                 short_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod, prod_s;
    logic [WIDTH-1:0]     quo, rem;

    assign signed_op = (op == 3'd0) || (op == 3'd2);
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign short_b   = (abs_b[WIDTH-1:HW] == '0);

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, ma_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: remainder high, dividend/quotient low.
    assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, mb_q};
    assign div_ok   = !div_diff[WIDTH];
    assign div_next = {div_ok ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0],
                       acc_q[WIDTH-2:0], div_ok};

    // An early-out multiply stops with the product still half-shifted.
    assign prod   = early_q ? (acc_q >> HW) : acc_q;
    assign prod_s = qneg_q ? -prod : prod;
    assign quo    = acc_q[WIDTH-1:0];
    assign rem    = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;
        early_d = early_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        div_d   = op[1];
                        ma_d    = abs_a;
                        mb_d    = abs_b;
                        bz_d    = (b == '0);
                        qneg_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = signed_op && a[WIDTH-1];
                        acc_d   = op[1] ? {{WIDTH{1'b0}}, abs_a}
                                        : {{WIDTH{1'b0}}, abs_b};
`ifdef MDU_EARLY_OUT_EN
                        early_d = !op[1] && short_b;
`else
                        early_d = 1'b0;
`endif
                    end else if (op == 3'd4) begin
                        hi_d = a;
                    end else if (op == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1) ||
                        (early_q && cnt_q == CW'(HW - 1))) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        lo_d = bz_q ? '1 : (qneg_q ? -quo : quo);
                        hi_d = rneg_q ? -rem : rem;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            early_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
            early_q <= early_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
